id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX operand forwarding. It feeds the EX-stage ALU directly.
//  - Latches the decoded instruction from ID.
//  - Selects each source operand from the register file, the EX/MEM result or the MEM/WB result.
//  - Applies shamt/immediate selection and presents ALUIn1/ALUIn2/ALUCtrl/Sign to the ALU.
//  - Optionally detects load-use hazards and inserts a bubble.
// PARAMETERS
//  DATA_W  32  operand/data width
//  REG_W   5   register-index width
// PORTS
//  clk           in   1       rising-edge clock
//  reset_n       in   1       synchronous, active-low reset
//  Stall         in   1       hold the stage contents
//  Flush         in   1       load a bubble
//  ID_Valid      in   1       ID holds a real instruction
//  ID_Rs         in   REG_W   rs index
//  ID_Rt         in   REG_W   rt index
//  ID_RsData     in   DATA_W  rs value read in ID
//  ID_RtData     in   DATA_W  rt value read in ID
//  ID_Imm        in   DATA_W  extended immediate
//  ID_Shamt      in   5       shift amount
//  ID_ALUSrc1    in   1       1: ALUIn1 = shamt
//  ID_ALUSrc2    in   1       1: ALUIn2 = immediate
//  ID_ALUCtrl    in   5       ALU operation code
//  ID_Sign       in   1       signed compare
//  ID_WrReg      in   REG_W   destination register
//  ID_RegWrite   in   1       instruction writes a register
//  ID_MemRead    in   1       instruction is a load
//  MEM_RegWrite  in   1       EX/MEM write enable
//  MEM_WrReg     in   REG_W   EX/MEM destination
//  MEM_ALUOut    in   DATA_W  EX/MEM result
//  WB_RegWrite   in   1       MEM/WB write enable
//  WB_WrReg      in   REG_W   MEM/WB destination
//  WB_Data       in   DATA_W  MEM/WB write-back data
//  EX_Valid      out  1       stage holds a real instruction
//  ALUIn1        out  DATA_W  ALU operand 1
//  ALUIn2        out  DATA_W  ALU operand 2
//  ALUCtrl       out  5       ALU operation code
//  Sign          out  1       signed compare
//  EX_StoreData  out  DATA_W  forwarded rt value, for stores
//  EX_WrReg      out  REG_W   destination register
//  EX_RegWrite   out  1       register write enable
//  EX_MemRead    out  1       instruction is a load
//  LoadUseStall  out  1       upstream must hold PC and IF/ID
// BEHAVIOUR
//  - Clocking: one clock, clk. Reset is synchronous and active-low on reset_n.
//  - Register update, evaluated at posedge in this priority order:
//    1. !reset_n: every stored field becomes 0.
//    2. Flush, or load-use bubble: store a bubble. Valid, RegWrite, MemRead, ALUCtrl and all data fields become 0.
//    3. Stall: keep all fields unchanged.
//    4. Otherwise: load every ID_* field.
//  - Reset values: EX_Valid=0, ALUCtrl=0, Sign=0, EX_RegWrite=0, EX_MemRead=0, EX_WrReg=0.
//    ALUIn1=0 and ALUIn2=0 provided the MEM/WB sources are idle.
//  - Latency: 1 cycle from ID_* to EX_*. Forwarding is combinational on the stored rs/rt.
//    Forwarding re-evaluates every cycle, including cycles under Stall.
//  - Forwarding for each source S in {rs, rt}:
//    - FwdS = MEM_ALUOut if MEM_RegWrite && MEM_WrReg!=0 && MEM_WrReg==S.
//    - else FwdS = WB_Data if WB_RegWrite && WB_WrReg!=0 && WB_WrReg==S.
//    - else FwdS = the stored register-file value.
//    - MEM has priority over WB. Register 0 is never forwarded.
//  - Operand selection:
//    - ALUIn1 = ALUSrc1 ? {27'b0, Shamt} : FwdRs
//    - ALUIn2 = ALUSrc2 ? Imm : FwdRt
//    - EX_StoreData = FwdRt always, independent of ALUSrc2.
//  - Flush together with Stall: Flush wins and a bubble is loaded.
//  - Reset mid-stall: reset wins and the stage is emptied.
// CONFIGURATION
//  LOAD_USE_DETECT_EN defined:
//   - LoadUseStall = EX_Valid & EX_MemRead & EX_WrReg!=0 & ID_Valid & (ID_Rs==EX_WrReg | ID_Rt==EX_WrReg).
//   - The condition is combinational from stored EX fields and the ID inputs.
//   - While it is asserted and neither reset nor Flush applies, the next edge loads a bubble, overriding Stall.
//   - Upstream holds ID, so the dependent instruction enters one cycle later and gets its value through WB forwarding.
//  LOAD_USE_DETECT_EN undefined:
//   - LoadUseStall is tied to 0.
//   - Load-use hazards are the responsibility of an external hazard unit, via Stall and Flush.
// TESTING
//  1. Hold reset_n=0 for 2 edges with garbage on ID_*
//     -> EX_Valid=0, ALUCtrl=0, EX_RegWrite=0, ALUIn1=ALUIn2=0 (WB/MEM idle).
//  2. Load rs=3, rt=4, RsData=5, RtData=7, ALUCtrl=00010, no forwarding
//     -> one cycle later ALUIn1=5, ALUIn2=7, EX_Valid=1.
//  3. Same instruction with MEM writing r3=0x11 and WB writing r3=0x22 and r4=0x33
//     -> ALUIn1=0x11, ALUIn2=0x33, EX_StoreData=0x33.
//  4. rs=0 with MEM_RegWrite=1, MEM_WrReg=0, MEM_ALUOut=0xFF, RsData=0
//     -> ALUIn1=0. ALUSrc1=1 with Shamt=9 -> ALUIn1=9.
//  5. Stall=1 for 3 cycles with new ID_* values
//     -> EX fields unchanged. Flush=1 with Stall=1 -> bubble, EX_RegWrite=0.
//  6. (EN) lw writing r8 held in EX, ID instruction has rs=8
//     -> LoadUseStall=1 and a bubble the next cycle. Retry with WB writing r8=0x44 -> ALUIn1=0x44.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding (MEM over WB, r0 never forwarded).
// Optional load-use bubble insertion enabled by defining LOAD_USE_DETECT_EN.
`default_nettype none

module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              ID_Valid,
  input  logic [REG_W-1:0]  ID_Rs,
  input  logic [REG_W-1:0]  ID_Rt,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic [4:0]        ID_Shamt,
  input  logic              ID_ALUSrc1,
  input  logic              ID_ALUSrc2,
  input  logic [4:0]        ID_ALUCtrl,
  input  logic              ID_Sign,
  input  logic [REG_W-1:0]  ID_WrReg,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              MEM_RegWrite,
  input  logic [REG_W-1:0]  MEM_WrReg,
  input  logic [DATA_W-1:0] MEM_ALUOut,
  input  logic              WB_RegWrite,
  input  logic [REG_W-1:0]  WB_WrReg,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              EX_Valid,
  output logic [DATA_W-1:0] ALUIn1,
  output logic [DATA_W-1:0] ALUIn2,
  output logic [4:0]        ALUCtrl,
  output logic              Sign,
  output logic [DATA_W-1:0] EX_StoreData,
  output logic [REG_W-1:0]  EX_WrReg,
  output logic              EX_RegWrite,
  output logic              EX_MemRead,
  output logic              LoadUseStall
);

  logic              valid_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [4:0]        shamt_q;
  logic              alu_src1_q;
  logic              alu_src2_q;
  logic [4:0]        alu_ctrl_q;
  logic              sign_q;
  logic [REG_W-1:0]  wr_reg_q;
  logic              reg_write_q;
  logic              mem_read_q;

  logic              load_use;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

`ifdef LOAD_USE_DETECT_EN
  assign load_use = valid_q & mem_read_q & (wr_reg_q != '0) & ID_Valid &
                    ((ID_Rs == wr_reg_q) | (ID_Rt == wr_reg_q));
`else
  assign load_use = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n || Flush || load_use) begin
      // Reset and bubble both empty every stored field.
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      alu_src1_q  <= 1'b0;
      alu_src2_q  <= 1'b0;
      alu_ctrl_q  <= '0;
      sign_q      <= 1'b0;
      wr_reg_q    <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else if (!Stall) begin
      valid_q     <= ID_Valid;
      rs_q        <= ID_Rs;
      rt_q        <= ID_Rt;
      rs_data_q   <= ID_RsData;
      rt_data_q   <= ID_RtData;
      imm_q       <= ID_Imm;
      shamt_q     <= ID_Shamt;
      alu_src1_q  <= ID_ALUSrc1;
      alu_src2_q  <= ID_ALUSrc2;
      alu_ctrl_q  <= ID_ALUCtrl;
      sign_q      <= ID_Sign;
      wr_reg_q    <= ID_WrReg;
      reg_write_q <= ID_RegWrite;
      mem_read_q  <= ID_MemRead;
    end
  end

  // The younger result in EX/MEM takes precedence over MEM/WB.
  always_comb begin
    fwd_rs = rs_data_q;
    if (MEM_RegWrite && (MEM_WrReg != '0) && (MEM_WrReg == rs_q))
      fwd_rs = MEM_ALUOut;
    else if (WB_RegWrite && (WB_WrReg != '0) && (WB_WrReg == rs_q))
      fwd_rs = WB_Data;
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (MEM_RegWrite && (MEM_WrReg != '0) && (MEM_WrReg == rt_q))
      fwd_rt = MEM_ALUOut;
    else if (WB_RegWrite && (WB_WrReg != '0) && (WB_WrReg == rt_q))
      fwd_rt = WB_Data;
  end

  assign ALUIn1       = alu_src1_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
  assign ALUIn2       = alu_src2_q ? imm_q : fwd_rt;
  assign EX_StoreData = fwd_rt;
  assign EX_Valid     = valid_q;
  assign ALUCtrl      = alu_ctrl_q;
  assign Sign         = sign_q;
  assign EX_WrReg     = wr_reg_q;
  assign EX_RegWrite  = reg_write_q;
  assign EX_MemRead   = mem_read_q;
  assign LoadUseStall = load_use;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
`default_nettype none

module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Stall, Flush;
  logic        ID_Valid;
  logic [4:0]  ID_Rs, ID_Rt;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic [4:0]  ID_Shamt;
  logic        ID_ALUSrc1, ID_ALUSrc2;
  logic [4:0]  ID_ALUCtrl;
  logic        ID_Sign;
  logic [4:0]  ID_WrReg;
  logic        ID_RegWrite, ID_MemRead;
  logic        MEM_RegWrite;
  logic [4:0]  MEM_WrReg;
  logic [31:0] MEM_ALUOut;
  logic        WB_RegWrite;
  logic [4:0]  WB_WrReg;
  logic [31:0] WB_Data;
  logic        EX_Valid;
  logic [31:0] ALUIn1, ALUIn2;
  logic [4:0]  ALUCtrl;
  logic        Sign;
  logic [31:0] EX_StoreData;
  logic [4:0]  EX_WrReg;
  logic        EX_RegWrite, EX_MemRead, LoadUseStall;

  int passed = 0;
  int total  = 0;

  id_ex_operand_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .Stall(Stall), .Flush(Flush),
    .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
    .ID_Shamt(ID_Shamt), .ID_ALUSrc1(ID_ALUSrc1), .ID_ALUSrc2(ID_ALUSrc2),
    .ID_ALUCtrl(ID_ALUCtrl), .ID_Sign(ID_Sign), .ID_WrReg(ID_WrReg),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .MEM_RegWrite(MEM_RegWrite), .MEM_WrReg(MEM_WrReg), .MEM_ALUOut(MEM_ALUOut),
    .WB_RegWrite(WB_RegWrite), .WB_WrReg(WB_WrReg), .WB_Data(WB_Data),
    .EX_Valid(EX_Valid), .ALUIn1(ALUIn1), .ALUIn2(ALUIn2), .ALUCtrl(ALUCtrl),
    .Sign(Sign), .EX_StoreData(EX_StoreData), .EX_WrReg(EX_WrReg),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .LoadUseStall(LoadUseStall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                        input logic [4:0] sh, input logic s1, input logic s2, input logic [4:0] ctrl,
                        input logic [4:0] wr, input logic rw, input logic mr);
    ID_Valid = v; ID_Rs = rs; ID_Rt = rt; ID_RsData = rsd; ID_RtData = rtd; ID_Imm = imm;
    ID_Shamt = sh; ID_ALUSrc1 = s1; ID_ALUSrc2 = s2; ID_ALUCtrl = ctrl; ID_Sign = 1'b0;
    ID_WrReg = wr; ID_RegWrite = rw; ID_MemRead = mr;
  endtask

  task automatic idle_fwd();
    MEM_RegWrite = 0; MEM_WrReg = 0; MEM_ALUOut = 0;
    WB_RegWrite = 0; WB_WrReg = 0; WB_Data = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; Stall = 0; Flush = 0; idle_fwd();
    set_id(1, 5'd7, 5'd9, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234, 5'd31, 1, 1, 5'd17, 5'd12, 1, 1);
    ID_Sign = 1;
    tick(); tick();
    total++; if (EX_Valid !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", EX_Valid); else passed++;
    total++; if (ALUCtrl !== 5'd0) $display("FAIL reset_aluctrl: got %0h expected 0", ALUCtrl); else passed++;
    total++; if (EX_RegWrite !== 1'b0) $display("FAIL reset_regwrite: got %0h expected 0", EX_RegWrite); else passed++;
    total++; if (EX_MemRead !== 1'b0) $display("FAIL reset_memread: got %0h expected 0", EX_MemRead); else passed++;
    total++; if (EX_WrReg !== 5'd0) $display("FAIL reset_wrreg: got %0h expected 0", EX_WrReg); else passed++;
    total++; if (Sign !== 1'b0) $display("FAIL reset_sign: got %0h expected 0", Sign); else passed++;
    total++; if (ALUIn1 !== 32'h0) $display("FAIL reset_aluin1: got %0h expected 0", ALUIn1); else passed++;
    total++; if (ALUIn2 !== 32'h0) $display("FAIL reset_aluin2: got %0h expected 0", ALUIn2); else passed++;
    total++; if (LoadUseStall !== 1'b0) $display("FAIL reset_lus: got %0h expected 0", LoadUseStall); else passed++;
  endtask

  task automatic test_load();
    reset_n = 1;
    set_id(1, 5'd3, 5'd4, 32'd5, 32'd7, 32'h100, 5'd9, 0, 0, 5'b00010, 5'd10, 1, 0);
    ID_Sign = 1;
    tick();
    total++; if (ALUIn1 !== 32'd5) $display("FAIL load_aluin1: got %0h expected 5", ALUIn1); else passed++;
    total++; if (ALUIn2 !== 32'd7) $display("FAIL load_aluin2: got %0h expected 7", ALUIn2); else passed++;
    total++; if (EX_Valid !== 1'b1) $display("FAIL load_valid: got %0h expected 1", EX_Valid); else passed++;
    total++; if (ALUCtrl !== 5'b00010) $display("FAIL load_aluctrl: got %0h expected 2", ALUCtrl); else passed++;
    total++; if (Sign !== 1'b1) $display("FAIL load_sign: got %0h expected 1", Sign); else passed++;
    total++; if (EX_WrReg !== 5'd10) $display("FAIL load_wrreg: got %0h expected a", EX_WrReg); else passed++;
    total++; if (EX_RegWrite !== 1'b1) $display("FAIL load_regwrite: got %0h expected 1", EX_RegWrite); else passed++;
    total++; if (EX_StoreData !== 32'd7) $display("FAIL load_storedata: got %0h expected 7", EX_StoreData); else passed++;
  endtask

  task automatic test_forwarding();
    MEM_RegWrite = 1; MEM_WrReg = 5'd3; MEM_ALUOut = 32'h11;
    WB_RegWrite = 1; WB_WrReg = 5'd3; WB_Data = 32'h22;
    #1;
    total++; if (ALUIn1 !== 32'h11) $display("FAIL fwd_mem_prio: got %0h expected 11", ALUIn1); else passed++;
    MEM_RegWrite = 0;
    #1;
    total++; if (ALUIn1 !== 32'h22) $display("FAIL fwd_wb_rs: got %0h expected 22", ALUIn1); else passed++;
    MEM_RegWrite = 1; WB_WrReg = 5'd4; WB_Data = 32'h33;
    #1;
    total++; if (ALUIn1 !== 32'h11) $display("FAIL fwd_mem_rs: got %0h expected 11", ALUIn1); else passed++;
    total++; if (ALUIn2 !== 32'h33) $display("FAIL fwd_wb_rt: got %0h expected 33", ALUIn2); else passed++;
    total++; if (EX_StoreData !== 32'h33) $display("FAIL fwd_store: got %0h expected 33", EX_StoreData); else passed++;
    WB_RegWrite = 0;
    #1;
    total++; if (ALUIn2 !== 32'd7) $display("FAIL fwd_wb_off: got %0h expected 7", ALUIn2); else passed++;
    WB_RegWrite = 1;
  endtask

  task automatic test_r0_and_select();
    // MEM targets r0 with a nonzero value; WB still writes r4=0x33.
    MEM_RegWrite = 1; MEM_WrReg = 5'd0; MEM_ALUOut = 32'hFF;
    set_id(1, 5'd0, 5'd4, 32'd0, 32'd7, 32'h100, 5'd9, 0, 0, 5'd1, 5'd10, 1, 0);
    tick();
    total++; if (ALUIn1 !== 32'h0) $display("FAIL r0_nofwd: got %0h expected 0", ALUIn1); else passed++;
    set_id(1, 5'd0, 5'd4, 32'd0, 32'd7, 32'h100, 5'd9, 1, 1, 5'd3, 5'd10, 1, 0);
    tick();
    total++; if (ALUIn1 !== 32'd9) $display("FAIL shamt_sel: got %0h expected 9", ALUIn1); else passed++;
    total++; if (ALUIn2 !== 32'h100) $display("FAIL imm_sel: got %0h expected 100", ALUIn2); else passed++;
    total++; if (EX_StoreData !== 32'h33) $display("FAIL store_indep: got %0h expected 33", EX_StoreData); else passed++;
  endtask

  task automatic test_stall_flush();
    Stall = 1;
    set_id(1, 5'd6, 5'd7, 32'hAA, 32'hBB, 32'h200, 5'd2, 0, 0, 5'd15, 5'd20, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ALUIn1 !== 32'd9) $display("FAIL stall_aluin1[%0d]: got %0h expected 9", i, ALUIn1); else passed++;
      total++; if (ALUCtrl !== 5'd3) $display("FAIL stall_aluctrl[%0d]: got %0h expected 3", i, ALUCtrl); else passed++;
      total++; if (EX_WrReg !== 5'd10) $display("FAIL stall_wrreg[%0d]: got %0h expected a", i, EX_WrReg); else passed++;
    end
    WB_Data = 32'h55;
    #1;
    total++; if (EX_StoreData !== 32'h55) $display("FAIL stall_fwd: got %0h expected 55", EX_StoreData); else passed++;
    Flush = 1;
    tick();
    total++; if (EX_Valid !== 1'b0) $display("FAIL flush_valid: got %0h expected 0", EX_Valid); else passed++;
    total++; if (EX_RegWrite !== 1'b0) $display("FAIL flush_regwrite: got %0h expected 0", EX_RegWrite); else passed++;
    total++; if (ALUCtrl !== 5'd0) $display("FAIL flush_aluctrl: got %0h expected 0", ALUCtrl); else passed++;
    total++; if (ALUIn1 !== 32'd0) $display("FAIL flush_aluin1: got %0h expected 0", ALUIn1); else passed++;
    total++; if (EX_MemRead !== 1'b0) $display("FAIL flush_memread: got %0h expected 0", EX_MemRead); else passed++;
    Flush = 0; Stall = 0; idle_fwd();
  endtask

  task automatic test_back_to_back();
    set_id(1, 5'd1, 5'd2, 32'h10, 32'h20, 32'h0, 5'd0, 0, 0, 5'd4, 5'd5, 1, 0);
    tick();
    set_id(1, 5'd11, 5'd12, 32'h30, 32'h40, 32'h0, 5'd0, 0, 0, 5'd6, 5'd7, 1, 0);
    total++; if (ALUIn1 + ALUIn2 !== 32'h30) $display("FAIL b2b_first: got %0h expected 30", ALUIn1 + ALUIn2); else passed++;
    total++; if (EX_WrReg !== 5'd5) $display("FAIL b2b_first_wr: got %0h expected 5", EX_WrReg); else passed++;
    tick();
    total++; if (ALUIn1 !== 32'h30) $display("FAIL b2b_second_in1: got %0h expected 30", ALUIn1); else passed++;
    total++; if (ALUIn2 !== 32'h40) $display("FAIL b2b_second_in2: got %0h expected 40", ALUIn2); else passed++;
    total++; if (ALUCtrl !== 5'd6) $display("FAIL b2b_second_ctrl: got %0h expected 6", ALUCtrl); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    Stall = 1; reset_n = 0;
    tick();
    total++; if (EX_Valid !== 1'b0) $display("FAIL rst_stall_valid: got %0h expected 0", EX_Valid); else passed++;
    total++; if (EX_WrReg !== 5'd0) $display("FAIL rst_stall_wrreg: got %0h expected 0", EX_WrReg); else passed++;
    Stall = 0; reset_n = 1;
  endtask

  task automatic test_load_use();
    // lw r8 <- ... enters EX; the next ID instruction reads r8.
    set_id(1, 5'd1, 5'd2, 32'h0, 32'h0, 32'h4, 5'd0, 0, 1, 5'd2, 5'd8, 1, 1);
    tick();
    set_id(1, 5'd8, 5'd5, 32'h99, 32'h1, 32'h0, 5'd0, 0, 0, 5'd2, 5'd9, 1, 0);
    #1;
`ifdef LOAD_USE_DETECT_EN
    total++; if (LoadUseStall !== 1'b1) $display("FAIL lu_detect: got %0h expected 1", LoadUseStall); else passed++;
    Stall = 1;
    tick();
    Stall = 0;
    total++; if (EX_Valid !== 1'b0) $display("FAIL lu_bubble: got %0h expected 0", EX_Valid); else passed++;
    total++; if (LoadUseStall !== 1'b0) $display("FAIL lu_clear: got %0h expected 0", LoadUseStall); else passed++;
    WB_RegWrite = 1; WB_WrReg = 5'd8; WB_Data = 32'h44;
    tick();
    total++; if (EX_Valid !== 1'b1) $display("FAIL lu_retry_valid: got %0h expected 1", EX_Valid); else passed++;
    total++; if (ALUIn1 !== 32'h44) $display("FAIL lu_retry_fwd: got %0h expected 44", ALUIn1); else passed++;
`else
    total++; if (LoadUseStall !== 1'b0) $display("FAIL lu_tied: got %0h expected 0", LoadUseStall); else passed++;
    tick();
    total++; if (EX_Valid !== 1'b1) $display("FAIL lu_nobubble: got %0h expected 1", EX_Valid); else passed++;
    total++; if (ALUIn1 !== 32'h99) $display("FAIL lu_stale: got %0h expected 99", ALUIn1); else passed++;
    WB_RegWrite = 1; WB_WrReg = 5'd8; WB_Data = 32'h44;
    #1;
    total++; if (ALUIn1 !== 32'h44) $display("FAIL lu_wb_fwd: got %0h expected 44", ALUIn1); else passed++;
`endif
    idle_fwd();
  endtask

  initial begin
    test_reset();
    test_load();
    test_forwarding();
    test_r0_and_select();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid_stall();
    test_load_use();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
